// File: rtl/song_sequencer.sv
// Multi-voice square-wave song player: walks a synchronous note ROM, runs one
// square-wave voice per channel and mixes them into one signed audio sample.

module song_voice #(
  parameter int          NOTE_W = 19,
  parameter logic [31:0] AMP    = 32'd1000000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              latch,
  input  logic              run,
  input  logic              en,
  input  logic [NOTE_W-1:0] half_in,
  output logic signed [31:0] contrib
);
  logic [NOTE_W-1:0] half, cnt;
  logic              phase;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      half  <= '0;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (latch) begin
      half  <= half_in;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (run) begin
      if (half == '0) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == half) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt   <= cnt + NOTE_W'(1);
      end
    end
  end

  // A zero half-period is a rest: the voice drops out of the mix entirely.
  always_comb begin
    contrib = '0;
    if (en && half != '0) contrib = phase ? $signed(AMP) : -$signed(AMP);
  end
endmodule

module song_sequencer #(
  parameter int          CHANNELS = 2,
  parameter int          NOTE_W   = 19,
  parameter int          ADDR_W   = 10,
  parameter int          DUR_W    = 27,
  parameter logic [31:0] AMP      = 32'd1000000000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  input  logic                       loop,
  input  logic [DUR_W-1:0]           tempo_limit,
  input  logic [ADDR_W-1:0]          last_addr,
  input  logic [CHANNELS-1:0]        chan_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [CHANNELS*NOTE_W-1:0] rom_q,
  output logic signed [31:0]         sample_out,
  output logic                       playing,
  output logic                       song_end
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, DONE} state_t;

  state_t                     state, state_d;
  logic [ADDR_W-1:0]          addr_d;
  logic [DUR_W-1:0]           dur_cnt, dur_lim;
  logic                       latch, run;
  logic [CHANNELS-1:0][31:0]  contrib;
  logic signed [31:0]         mix;

  assign latch    = (state == LATCH);
  assign run      = (state == PLAY) && !pause;
  assign playing  = (state == FETCH) || (state == LATCH) || (state == PLAY);
  assign song_end = (state == DONE);

  always_comb begin
    state_d = state;
    addr_d  = rom_addr;
    case (state)
      IDLE, DONE: if (start) begin
        state_d = FETCH;
        addr_d  = '0;
      end
      FETCH: state_d = LATCH;
      LATCH: state_d = PLAY;
      PLAY: if (!pause && dur_cnt == dur_lim) begin
        if (rom_addr != last_addr) begin
          addr_d  = rom_addr + ADDR_W'(1);
          state_d = FETCH;
        end else if (loop) begin
          addr_d  = '0;
          state_d = FETCH;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // stop overrides everything, including a same-cycle start
    if (stop) begin
      state_d = IDLE;
      addr_d  = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      rom_addr   <= '0;
      dur_cnt    <= '0;
      dur_lim    <= '0;
      sample_out <= '0;
    end else begin
      state    <= state_d;
      rom_addr <= addr_d;
      // tempo is sampled once per note so mid-note changes land on the next note
      if (latch) begin
        dur_cnt <= '0;
        dur_lim <= tempo_limit;
      end else if (run) begin
        dur_cnt <= dur_cnt + DUR_W'(1);
      end
      sample_out <= (run && !stop) ? mix : '0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
    song_voice #(.NOTE_W(NOTE_W), .AMP(AMP)) u_voice (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .latch    (latch),
      .run      (run),
      .en       (chan_en[i]),
      .half_in  (rom_q[i*NOTE_W +: NOTE_W]),
      .contrib  (contrib[i])
    );
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < CHANNELS; i++) mix = mix + $signed(contrib[i]);
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: small ROM model, hand-timed steps and
// immediate-assertion checks against hand-computed values.

module tb_song_sequencer;
  localparam int CH = 2, NW = 19, AW = 10, DW = 27;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
  logic [DW-1:0]        tempo_limit;
  logic [AW-1:0]        last_addr, rom_addr;
  logic [CH-1:0]        chan_en;
  logic [CH*NW-1:0]     rom_q;
  logic signed [31:0]   sample_out;
  logic                 playing, song_end;
  logic [CH*NW-1:0]     rom [4];
  int                   checks = 0, errors = 0, tnow = 0;

  song_sequencer #(.CHANNELS(CH), .NOTE_W(NW), .ADDR_W(AW), .DUR_W(DW), .AMP(32'd1000)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .loop        (loop),
    .tempo_limit (tempo_limit),
    .last_addr   (last_addr),
    .chan_en     (chan_en),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .sample_out  (sample_out),
    .playing     (playing),
    .song_end    (song_end)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // registered-address ROM: data follows the address one cycle later
  always @(posedge CLOCK_50) rom_q <= rom[rom_addr[1:0]];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance to negedge number tt, counted from the last start reference
  task automatic at(input int tt);
    repeat (tt - tnow) @(negedge CLOCK_50);
    tnow = tt;
  endtask

  initial begin
    rom[0] = {19'd0, 19'd4};
    rom[1] = {19'd3, 19'd3};
    rom[2] = {19'd0, 19'd2};
    rom[3] = {19'd0, 19'd1};
    tempo_limit = 27'd9;
    last_addr   = 10'd2;
    chan_en     = 2'b11;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_addr",     32'(rom_addr), 0);
    chk("rst_sample",   sample_out, 0);
    chk("rst_playing",  32'(playing), 0);
    chk("rst_song_end", 32'(song_end), 0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    // basic sequence + mixing: 3 notes, tempo 9 -> a note every 12 cycles
    start = 1'b1; tnow = 0;
    at(1);  start = 1'b0;
    chk("b_playing", 32'(playing), 1);
    chk("b_addr0",   32'(rom_addr), 0);
    at(5);  chk("b_s5",  sample_out, -1000);
    at(8);  chk("b_s8",  sample_out, -1000);
    at(9);  chk("b_s9",  sample_out, 1000);
    at(13); chk("b_s13", sample_out, 1000);
    chk("b_addr1", 32'(rom_addr), 1);
    at(14); chk("b_s14_fetch", sample_out, 0);
    at(16); chk("m_both_neg", sample_out, -2000);
    at(20); chk("m_both_pos", sample_out, 2000);
    chan_en = 2'b01;
    at(21); chk("m_en01", sample_out, 1000);
    chan_en = 2'b00;
    at(22); chk("m_en00", sample_out, 0);
    chan_en = 2'b11;
    at(23); chk("m_en11", sample_out, 2000);
    at(24); chk("m_neg2", sample_out, -2000);
    at(25); chk("b_addr2", 32'(rom_addr), 2);
    at(36); chk("b_end_early", 32'(song_end), 0);
    at(37); chk("b_song_end", 32'(song_end), 1);
    chk("b_play_fall", 32'(playing), 0);
    chk("b_last_s",    sample_out, 1000);
    chk("b_addr_hold", 32'(rom_addr), 2);
    at(38); chk("b_done_s", sample_out, 0);
    at(40); chk("b_end_hold", 32'(song_end), 1);

    // pause 20 cycles in note 0, then stop in note 1
    start = 1'b1; tnow = 0;
    at(1);  start = 1'b0;
    at(5);  chk("p_pre", sample_out, -1000);
    pause = 1'b1;
    at(6);  chk("p_s6",  sample_out, 0);
    at(20); chk("p_s20", sample_out, 0);
    at(25); chk("p_s25", sample_out, 0);
    pause = 1'b0;
    at(26); chk("p_s26", sample_out, -1000);
    at(28); chk("p_s28", sample_out, -1000);
    at(29); chk("p_s29", sample_out, 1000);
    at(32); chk("p_addr_hold", 32'(rom_addr), 0);
    chk("p_playing", 32'(playing), 1);
    at(33); chk("p_addr_next", 32'(rom_addr), 1);
    at(38); chk("s_pre", sample_out, -2000);
    stop = 1'b1;
    at(39); chk("s_playing", 32'(playing), 0);
    chk("s_addr",   32'(rom_addr), 0);
    chk("s_sample", sample_out, 0);
    chk("s_end",    32'(song_end), 0);
    stop = 1'b0;
    at(40); start = 1'b1; stop = 1'b1;
    at(41); chk("ss_playing", 32'(playing), 0);
    chk("ss_addr", 32'(rom_addr), 0);
    start = 1'b0; stop = 1'b0;

    // loop over a 2-note song at tempo 4, then drop loop during note 1
    at(42); loop = 1'b1; last_addr = 10'd1; tempo_limit = 27'd4;
    start = 1'b1; tnow = 0;
    at(1);  start = 1'b0;
    at(7);  chk("l_addr7", 32'(rom_addr), 0);
    at(8);  chk("l_addr8", 32'(rom_addr), 1);
    at(15); chk("l_wrap",  32'(rom_addr), 0);
    chk("l_no_end", 32'(song_end), 0);
    chk("l_playing", 32'(playing), 1);
    at(22); chk("l_addr22", 32'(rom_addr), 1);
    at(25); loop = 1'b0;
    at(28); chk("l_end_early", 32'(song_end), 0);
    at(29); chk("l_done", 32'(song_end), 1);
    chk("l_done_addr", 32'(rom_addr), 1);

    // tempo 9 -> 4 mid-note: current note keeps 10 PLAY cycles, next gets 5
    at(31); tempo_limit = 27'd9;
    start = 1'b1; tnow = 0;
    at(1);  start = 1'b0;
    at(5);  tempo_limit = 27'd4;
    at(12); chk("t_addr12", 32'(rom_addr), 0);
    at(13); chk("t_addr13", 32'(rom_addr), 1);
    at(19); chk("t_end_early", 32'(song_end), 0);
    at(20); chk("t_done", 32'(song_end), 1);
    chk("t_play_fall", 32'(playing), 0);

    // one-note song with a single PLAY cycle
    at(22); tempo_limit = 27'd0; last_addr = 10'd0;
    start = 1'b1; tnow = 0;
    at(1);  start = 1'b0;
    at(3);  chk("z_playing", 32'(playing), 1);
    chk("z_end_early", 32'(song_end), 0);
    at(4);  chk("z_done", 32'(song_end), 1);
    chk("z_sample", sample_out, -1000);
    at(5);  chk("z_sample_off", sample_out, 0);

    // reset in the middle of note 1
    at(6);  tempo_limit = 27'd2; last_addr = 10'd3;
    start = 1'b1; tnow = 0;
    at(1);  start = 1'b0;
    at(9);  chk("r_pre_s", sample_out, -2000);
    chk("r_pre_addr", 32'(rom_addr), 1);
    reset = 1'b1;
    at(10); chk("r_addr", 32'(rom_addr), 0);
    chk("r_sample",   sample_out, 0);
    chk("r_playing",  32'(playing), 0);
    chk("r_song_end", 32'(song_end), 0);
    reset = 1'b0;
    at(12); chk("r_idle", 32'(playing), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
